// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 UART byte transmitter with Send_En strobe, busy and done flags.
// Optional even-parity bit after data bit 7 when UART_TX_PARITY_EN is defined.
module uart_byte_tx #(
  parameter int unsigned BPS_CNT_MAX = 5208 - 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Send_En,
  input  logic [7:0] Data_Byte,
  output logic       Rs232_Tx,
  output logic       Tx_Busy,
  output logic       Tx_Done
);

  localparam logic [15:0] DIV_LAST = 16'(BPS_CNT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t      state, state_n;
  logic [15:0] div_cnt, div_n;
  logic [2:0]  bit_idx, idx_n;
  logic [7:0]  tx_byte, byte_n;
  logic        tx_n, busy_n, done_n;
  logic        bit_end;

  assign bit_end = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      div_cnt  <= 16'd0;
      bit_idx  <= 3'd0;
      tx_byte  <= 8'd0;
      Rs232_Tx <= 1'b1;
      Tx_Busy  <= 1'b0;
      Tx_Done  <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_idx  <= idx_n;
      tx_byte  <= byte_n;
      Rs232_Tx <= tx_n;
      Tx_Busy  <= busy_n;
      Tx_Done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    idx_n   = bit_idx;
    byte_n  = tx_byte;
    if (state == IDLE) begin
      div_n = 16'd0;
      idx_n = 3'd0;
      if (Send_En) begin
        state_n = START;
        byte_n  = Data_Byte;
      end
    end else if (!bit_end) begin
      div_n = div_cnt + 16'd1;
    end else begin
      div_n = 16'd0;
      case (state)
        START: begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = bit_idx + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state_n = STOP;
`endif
        STOP: begin
          // A request on the last stop-bit clock chains the next frame with no idle gap.
          if (Send_En) begin
            state_n = START;
            byte_n  = Data_Byte;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (div_n == DIV_LAST);
    case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = byte_n[idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_n = ^byte_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb/tb_uart_byte_tx.sv - Scoreboard bench for uart_byte_tx, per-cycle line/busy/done expectations.
module tb_uart_byte_tx;

  localparam int B = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Send_En = 1'b0;
  logic [7:0] Data_Byte = 8'd0;
  logic       Rs232_Tx, Tx_Busy, Tx_Done;

  int tests = 0;
  int fails = 0;

  // Each entry is {tx, busy, done} expected for one clock cycle.
  logic [2:0] exp_q[$];

  uart_byte_tx #(.BPS_CNT_MAX(B - 1)) dut (
    .CLK(CLK), .RST(RST), .Send_En(Send_En), .Data_Byte(Data_Byte),
    .Rs232_Tx(Rs232_Tx), .Tx_Busy(Tx_Busy), .Tx_Done(Tx_Done)
  );

  always #5 CLK = ~CLK;

  task automatic push_bit(input logic val, input logic last);
    for (int c = 0; c < B; c++)
      exp_q.push_back({val, 1'b1, (last && c == B - 1)});
  endtask

  task automatic push_frame(input logic [7:0] b);
    push_bit(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) push_bit(b[k], 1'b0);
`ifdef UART_TX_PARITY_EN
    push_bit(^b, 1'b0);
`endif
    push_bit(1'b1, 1'b1);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(3'b100);
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    RST = 1'b1;
    Send_En = 1'b1;
    Data_Byte = 8'h00;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== 3'b100) begin
        fails++;
        $display("FAIL reset_state cycle %0d: got %b want 100", i, obs);
      end
      @(negedge CLK);
    end
    RST = 1'b0;
    Send_En = 1'b0;
    push_idle(2);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== exp_q[0]) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %b want %b", i, obs, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_single();
    logic [2:0] obs, e;
    int i;
    Send_En = 1'b1;
    Data_Byte = 8'h55;
    push_frame(8'h55);
    push_idle(3);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) begin
        Send_En = 1'b0;
        Data_Byte = 8'h00;
      end
      e = exp_q.pop_front();
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL single_0x55 cycle t+%0d: got %b want %b", i + 1, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_ignore_busy();
    logic [2:0] obs, e;
    int i;
    Send_En = 1'b1;
    Data_Byte = 8'hA3;
    push_frame(8'hA3);
    push_idle(2 * B + 2);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) Send_En = 1'b0;
      if (i == 10) begin
        Send_En = 1'b1;
        Data_Byte = 8'hFF;
      end
      if (i == 11) Send_En = 1'b0;
      e = exp_q.pop_front();
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL ignore_busy cycle t+%0d: got %b want %b", i + 1, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs, e;
    int i;
    int flen;
    flen = exp_q.size();
    push_frame(8'h00);
    flen = exp_q.size() - flen;
    push_frame(8'h81);
    push_idle(3);
    Send_En = 1'b1;
    Data_Byte = 8'h00;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) Data_Byte = 8'h81;
      if (i == flen) begin
        Send_En = 1'b0;
        Data_Byte = 8'h5A;
      end
      e = exp_q.pop_front();
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL back_to_back cycle t+%0d: got %b want %b", i + 1, obs, e);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] obs, e;
    int i;
    Send_En = 1'b1;
    Data_Byte = 8'h96;
    push_frame(8'h96);
    for (i = 0; i < 17; i++) begin
      @(negedge CLK);
      if (i == 0) Send_En = 1'b0;
      e = exp_q.pop_front();
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_pre cycle t+%0d: got %b want %b", i + 1, obs, e);
      end
    end
    RST = 1'b1;
    exp_q.delete();
    push_idle(3);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      RST = 1'b0;
      e = exp_q.pop_front();
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_drop cycle %0d: got %b want %b", i, obs, e);
      end
      i++;
    end
    Send_En = 1'b1;
    Data_Byte = 8'h3C;
    push_frame(8'h3C);
    push_idle(2);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      if (i == 0) Send_En = 1'b0;
      e = exp_q.pop_front();
      obs = {Rs232_Tx, Tx_Busy, Tx_Done};
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_mid_clean cycle t+%0d: got %b want %b", i + 1, obs, e);
      end
      i++;
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_single();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
